// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared types, default parameters and next-state helpers for the RAM
// arbiter that lets the IFU and LSU share one single-port synchronous RAM.
//   owner_e       : which requester owns the read data returning next cycle
//   ARB_*         : default address/data widths and IFU starvation bound
//   next_wait()   : saturating IFU starvation counter update
//   next_owner()  : response owner recorded for the current grant
package ram_arbiter_pkg;

    localparam int ARB_AW       = 32;
    localparam int ARB_DW       = 32;
    localparam int ARB_MAX_WAIT = 4;
    localparam int WAIT_W       = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    // Counts cycles the IFU has been asking and losing; any grant or a
    // withdrawn request restarts the count.
    function automatic logic [WAIT_W-1:0] next_wait(
        input logic              if_req,
        input logic              if_gnt,
        input logic [WAIT_W-1:0] cnt,
        input logic [WAIT_W-1:0] max_cnt
    );
        logic [WAIT_W-1:0] nxt;
        if (if_req && !if_gnt) begin
            if (cnt == max_cnt) begin
                nxt = cnt;
            end else begin
                nxt = cnt + 4'd1;
            end
        end else begin
            nxt = 4'd0;
        end
        return nxt;
    endfunction

    // Only reads produce a response, so writes and idle cycles record NONE.
    function automatic owner_e next_owner(
        input logic if_win,
        input logic ls_win,
        input logic ls_we
    );
        owner_e nxt;
        if (if_win) begin
            nxt = OWN_IF;
        end else if (ls_win && !ls_we) begin
            nxt = OWN_LS;
        end else begin
            nxt = OWN_NONE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
// Bundles the IFU request port, LSU request port and RAM-side port of the
// arbiter.
//   slave  : the arbiter's view (takes requests and ram_rdata, drives
//            grants, responses and the RAM command)
//   master : the surrounding system's view (requesters plus RAM)
interface ram_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // IFU: word reads only
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [DW-1:0]   if_rdata;

    // LSU: byte-lane reads and writes
    logic            ls_req;
    logic            ls_we;
    logic [AW-1:0]   ls_addr;
    logic [DW-1:0]   ls_wdata;
    logic [DW/8-1:0] ls_wstrb;
    logic            ls_gnt;
    logic            ls_rvalid;
    logic [DW-1:0]   ls_rdata;

    // RAM port (read data arrives one cycle after ram_ren)
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW/8-1:0] ram_wen;
    logic            ram_ren;
    logic [DW-1:0]   ram_rdata;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
        input  ram_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output ram_addr, ram_wdata, ram_wen, ram_ren
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
        output ram_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  ram_addr, ram_wdata, ram_wen, ram_ren
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port synchronous RAM between the IFU (word reads) and
// the LSU (byte-lane reads/writes). One access per cycle, granted in the
// same cycle as the request. The LSU has fixed priority, except that once
// the IFU has been denied MAX_WAIT consecutive cycles it wins the next
// arbitration. Read data (1-cycle latency) is routed back to the requester
// recorded in the owner register.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset; also masks grants, RAM commands
//          and responses while high
//   bus  : ram_arbiter_if.slave (IFU, LSU and RAM-side signals)
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AW       = ARB_AW,
    parameter int DW       = ARB_DW,
    parameter int MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic            clk,
    input  logic            rst,
    ram_arbiter_if.slave    bus
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    owner_e            owner_r;
    logic [WAIT_W-1:0] wait_cnt_r;

    logic              starved_s;
    logic              if_win_s;
    logic              ls_win_s;

    logic [AW-1:0]     ram_addr_s;
    logic [DW-1:0]     ram_wdata_s;
    logic [DW/8-1:0]   ram_wen_s;
    logic              ram_ren_s;

    logic              if_rvalid_s;
    logic              ls_rvalid_s;
    logic [DW-1:0]     if_rdata_s;
    logic [DW-1:0]     ls_rdata_s;

    // Arbitration: LSU first unless the IFU has hit its starvation bound.
    always_comb begin
        starved_s = (wait_cnt_r == MAX_WAIT_C);
        if_win_s  = 1'b0;
        ls_win_s  = 1'b0;
        if (rst) begin
            if_win_s = 1'b0;
            ls_win_s = 1'b0;
        end else if (bus.ls_req && !(bus.if_req && starved_s)) begin
            ls_win_s = 1'b1;
        end else if (bus.if_req) begin
            if_win_s = 1'b1;
        end else begin
            if_win_s = 1'b0;
            ls_win_s = 1'b0;
        end
    end

    // RAM command for the winner; an idle cycle drives all zeros.
    always_comb begin
        ram_addr_s  = {AW{1'b0}};
        ram_wdata_s = {DW{1'b0}};
        ram_wen_s   = {(DW/8){1'b0}};
        ram_ren_s   = 1'b0;
        if (if_win_s) begin
            ram_addr_s = bus.if_addr;
            ram_ren_s  = 1'b1;
        end else if (ls_win_s) begin
            ram_addr_s = bus.ls_addr;
            if (bus.ls_we) begin
                // A zero strobe still uses the slot; it just writes nothing.
                ram_wdata_s = bus.ls_wdata;
                ram_wen_s   = bus.ls_wstrb;
            end else begin
                ram_ren_s = 1'b1;
            end
        end else begin
            ram_ren_s = 1'b0;
        end
    end

    // Response routing; gated by rst so a read granted just before reset
    // is dropped instead of being reported during reset.
    always_comb begin
        if_rvalid_s = 1'b0;
        ls_rvalid_s = 1'b0;
        if (rst) begin
            if_rvalid_s = 1'b0;
            ls_rvalid_s = 1'b0;
        end else begin
            case (owner_r)
                OWN_IF:   if_rvalid_s = 1'b1;
                OWN_LS:   ls_rvalid_s = 1'b1;
                OWN_NONE: begin
                    if_rvalid_s = 1'b0;
                    ls_rvalid_s = 1'b0;
                end
                default: begin
                    if_rvalid_s = 1'b0;
                    ls_rvalid_s = 1'b0;
                end
            endcase
        end
        if_rdata_s = if_rvalid_s ? bus.ram_rdata : {DW{1'b0}};
        ls_rdata_s = ls_rvalid_s ? bus.ram_rdata : {DW{1'b0}};
    end

    // Response owner and IFU starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r    <= OWN_NONE;
            wait_cnt_r <= 4'd0;
        end else begin
            owner_r    <= next_owner(if_win_s, ls_win_s, bus.ls_we);
            wait_cnt_r <= next_wait(bus.if_req, if_win_s, wait_cnt_r, MAX_WAIT_C);
        end
    end

    assign bus.if_gnt    = if_win_s;
    assign bus.ls_gnt    = ls_win_s;
    assign bus.if_rvalid = if_rvalid_s;
    assign bus.ls_rvalid = ls_rvalid_s;
    assign bus.if_rdata  = if_rdata_s;
    assign bus.ls_rdata  = ls_rdata_s;
    assign bus.ram_addr  = ram_addr_s;
    assign bus.ram_wdata = ram_wdata_s;
    assign bus.ram_wen   = ram_wen_s;
    assign bus.ram_ren   = ram_ren_s;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter (MAX_WAIT = 4) with a small behavioural
// synchronous RAM. Inputs change on the falling edge; outputs for that
// cycle are checked 1 time unit later.
module tb_ram_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [31:0] mem [0:255];

    ram_arbiter_if #(.AW(32), .DW(32)) bus ();

    ram_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM, one-cycle read latency, word indexed.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.ram_wen[b]) mem[bus.ram_addr[9:2]][8*b +: 8] = bus.ram_wdata[8*b +: 8];
        end
        if (bus.ram_ren) bus.ram_rdata <= mem[bus.ram_addr[9:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'd64] = 32'hDEADBEEF;   // 0x100
        mem[8'd16] = 32'h11223344;   // 0x40
        mem[8'd0]  = 32'h0000000A;   // 0x0
        mem[8'd1]  = 32'h0000000B;   // 0x4

        rst          = 1'b1;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h4;
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b0;
        bus.ls_addr  = 32'h0;
        bus.ls_wdata = 32'h0;
        bus.ls_wstrb = 4'h0;

        // Reset hold with both requesting
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("rst_if_gnt",    32'(bus.if_gnt),    32'd0);
            check("rst_ls_gnt",    32'(bus.ls_gnt),    32'd0);
            check("rst_ram_ren",   32'(bus.ram_ren),   32'd0);
            check("rst_ram_wen",   32'(bus.ram_wen),   32'd0);
            check("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
            check("rst_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
            check("rst_if_rdata",  bus.if_rdata,       32'd0);
            check("rst_ls_rdata",  bus.ls_rdata,       32'd0);
        end

        // Release reset: LSU wins immediately
        @(negedge clk); rst = 1'b0; #1;
        check("rel_ls_gnt",   32'(bus.ls_gnt),  32'd1);
        check("rel_if_gnt",   32'(bus.if_gnt),  32'd0);
        check("rel_ram_ren",  32'(bus.ram_ren), 32'd1);
        check("rel_ram_addr", bus.ram_addr,     32'h0);

        // Idle: RAM port all zero, LSU read returns
        @(negedge clk); bus.if_req = 1'b0; bus.ls_req = 1'b0; #1;
        check("idle_ram_ren",   32'(bus.ram_ren),   32'd0);
        check("idle_ram_addr",  bus.ram_addr,       32'h0);
        check("idle_ram_wdata", bus.ram_wdata,      32'h0);
        check("idle_gnts",      {30'd0, bus.if_gnt, bus.ls_gnt}, 32'd0);
        check("rel_ls_rvalid",  32'(bus.ls_rvalid), 32'd1);
        check("rel_ls_rdata",   bus.ls_rdata,       32'h0000000A);
        check("rel_if_rvalid",  32'(bus.if_rvalid), 32'd0);

        // Single IFU read of 0x100
        @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 32'h100; #1;
        check("ifr_gnt",      32'(bus.if_gnt),  32'd1);
        check("ifr_ram_addr", bus.ram_addr,     32'h100);
        check("ifr_ram_ren",  32'(bus.ram_ren), 32'd1);
        check("ifr_ls_rvalid_prev", 32'(bus.ls_rvalid), 32'd0);
        @(negedge clk); bus.if_req = 1'b0; #1;
        check("ifr_rvalid",    32'(bus.if_rvalid), 32'd1);
        check("ifr_rdata",     bus.if_rdata,       32'hDEADBEEF);
        check("ifr_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
        check("ifr_ls_rdata",  bus.ls_rdata,       32'h0);

        // LSU byte write to 0x40 lane 1, then read back
        @(negedge clk);
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h40;
        bus.ls_wdata = 32'h0000AB00; bus.ls_wstrb = 4'b0010; #1;
        check("wr_gnt",       32'(bus.ls_gnt),    32'd1);
        check("wr_ram_wen",   32'(bus.ram_wen),   32'h2);
        check("wr_ram_ren",   32'(bus.ram_ren),   32'd0);
        check("wr_ram_wdata", bus.ram_wdata,      32'h0000AB00);
        check("wr_ram_addr",  bus.ram_addr,       32'h40);
        @(negedge clk); bus.ls_we = 1'b0; bus.ls_wstrb = 4'h0; #1;
        check("rd_gnt",        32'(bus.ls_gnt),    32'd1);
        check("wr_no_ls_rv",   32'(bus.ls_rvalid), 32'd0);
        check("wr_no_if_rv",   32'(bus.if_rvalid), 32'd0);
        @(negedge clk); bus.ls_req = 1'b0; #1;
        check("rd_rvalid",     32'(bus.ls_rvalid), 32'd1);
        check("rd_rdata",      bus.ls_rdata,       32'h1122AB44);

        // Zero-strobe write still wins over the IFU and consumes the slot
        @(negedge clk);
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_wstrb = 4'h0;
        bus.if_req = 1'b1; bus.if_addr = 32'h4; #1;
        check("z_ls_gnt",  32'(bus.ls_gnt),  32'd1);
        check("z_if_gnt",  32'(bus.if_gnt),  32'd0);
        check("z_ram_wen", 32'(bus.ram_wen), 32'd0);
        check("z_ram_ren", 32'(bus.ram_ren), 32'd0);
        @(negedge clk); bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.if_req = 1'b0; #1;
        check("z_no_rvalid", {30'd0, bus.if_rvalid, bus.ls_rvalid}, 32'd0);

        // Starvation guard: both requesting for 10 cycles
        bus.ls_addr = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); bus.ls_req = 1'b1; bus.if_req = 1'b1; #1;
            check("st_if_gnt",   32'(bus.if_gnt), ((i == 4) || (i == 9)) ? 32'd1 : 32'd0);
            check("st_ls_gnt",   32'(bus.ls_gnt), ((i == 4) || (i == 9)) ? 32'd0 : 32'd1);
            check("st_wait_cnt", 32'(dut.wait_cnt_r), 32'(i % 5));
            if (i > 0) begin
                check("st_if_rv", 32'(bus.if_rvalid), (i == 5) ? 32'd1 : 32'd0);
                check("st_ls_rv", 32'(bus.ls_rvalid), (i == 5) ? 32'd0 : 32'd1);
                check("st_rdata", (i == 5) ? bus.if_rdata : bus.ls_rdata,
                      (i == 5) ? 32'h0000000B : 32'h0000000A);
            end else begin
                check("st_rv0", {30'd0, bus.if_rvalid, bus.ls_rvalid}, 32'd0);
            end
        end

        // Interleaved LS(0x0) / IF(0x4), responses one cycle behind
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.ls_req = ((k % 2) == 0);
            bus.if_req = ((k % 2) == 1);
            #1;
            check("il_ls_gnt", 32'(bus.ls_gnt), ((k % 2) == 0) ? 32'd1 : 32'd0);
            check("il_if_gnt", 32'(bus.if_gnt), ((k % 2) == 1) ? 32'd1 : 32'd0);
            check("il_if_rv",  32'(bus.if_rvalid), ((k % 2) == 0) ? 32'd1 : 32'd0);
            check("il_ls_rv",  32'(bus.ls_rvalid), ((k % 2) == 1) ? 32'd1 : 32'd0);
            check("il_if_rd",  bus.if_rdata, ((k % 2) == 0) ? 32'h0000000B : 32'h0);
            check("il_ls_rd",  bus.ls_rdata, ((k % 2) == 1) ? 32'h0000000A : 32'h0);
        end
        @(negedge clk); bus.ls_req = 1'b0; bus.if_req = 1'b0; #1;
        check("il_last_if_rv", 32'(bus.if_rvalid), 32'd1);
        check("il_last_ls_rv", 32'(bus.ls_rvalid), 32'd0);
        check("il_last_if_rd", bus.if_rdata,       32'h0000000B);

        // Reset right after an IFU read grant drops the response
        @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 32'h100; #1;
        check("mr_gnt", 32'(bus.if_gnt), 32'd1);
        @(negedge clk); rst = 1'b1; #1;
        check("mr_rst_gnt",    32'(bus.if_gnt),    32'd0);
        check("mr_rst_ren",    32'(bus.ram_ren),   32'd0);
        check("mr_rst_rvalid", 32'(bus.if_rvalid), 32'd0);
        check("mr_rst_rdata",  bus.if_rdata,       32'h0);
        @(negedge clk); rst = 1'b0; #1;
        check("mr_post_rvalid", 32'(bus.if_rvalid), 32'd0);
        check("mr_post_gnt",    32'(bus.if_gnt),    32'd1);
        @(negedge clk); bus.if_req = 1'b0; #1;
        check("mr_new_rvalid", 32'(bus.if_rvalid), 32'd1);
        check("mr_new_rdata",  bus.if_rdata,       32'hDEADBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares one single-port synchronous RAM between the instruction-fetch unit (IFU, word reads only) and the load/store unit (LSU, byte-lane reads/writes). It sits between the two requesters and the RAM-side port of the memory interface. It issues at most one RAM access per cycle and routes each 1-cycle-latency read response back to its owner. The LSU has fixed priority, and a starvation counter guarantees the IFU forward progress.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width; byte strobes are `DW/8`
- `MAX_WAIT`, 4, consecutive denied IFU cycles after which the IFU wins the next arbitration (1..15)

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `if_req`  in  1  IFU read request
- `if_addr`  in  AW  IFU word address
- `if_gnt`  out  1  IFU request accepted this cycle
- `if_rvalid`  out  1  IFU read data valid
- `if_rdata`  out  DW  IFU read data
- `ls_req`  in  1  LSU request
- `ls_we`  in  1  1 = write, 0 = read
- `ls_addr`  in  AW  LSU address
- `ls_wdata`  in  DW  lane-aligned write data
- `ls_wstrb`  in  DW/8  write byte enables
- `ls_gnt`  out  1  LSU request accepted this cycle
- `ls_rvalid`  out  1  LSU read data valid (reads only)
- `ls_rdata`  out  DW  LSU read data
- `ram_addr`  out  AW  RAM address
- `ram_wdata`  out  DW  RAM write data
- `ram_wen`  out  DW/8  RAM byte write enables
- `ram_ren`  out  1  RAM read enable
- `ram_rdata`  in  DW  RAM read data, valid one cycle after `ram_ren`

## Operation
Arbitration is combinational and happens every cycle. There are no bubbles: a new grant can be issued every cycle.
- Neither request: no grant; `ram_ren` = 0, `ram_wen` = 0, `ram_addr` = 0, `ram_wdata` = 0.
- Only one request: that requester is granted.
- Both requests: the LSU is granted, unless `wait_cnt == MAX_WAIT`, in which case the IFU is granted.

Effect of a grant on the RAM port:
- IFU grant: `ram_addr` = `if_addr`, `ram_ren` = 1, `ram_wen` = 0.
- LSU read grant: `ram_addr` = `ls_addr`, `ram_ren` = 1.
- LSU write grant: `ram_addr` = `ls_addr`, `ram_wdata` = `ls_wdata`, `ram_wen` = `ls_wstrb`, `ram_ren` = 0.
- An LSU write with `ls_wstrb` = 0 is still granted and consumes the slot.

Starvation counter `wait_cnt`:
- Increments when `if_req && !if_gnt`, saturating at `MAX_WAIT`.
- Clears to 0 when `if_gnt` or `!if_req`.

Response routing:
- Register `owner` holds {NONE, IF, LS} and records the read grant of the previous cycle. Writes record NONE.
- The following cycle, exactly one of `if_rvalid` / `ls_rvalid` equals 1 per `owner`.
- The selected `*_rdata` = `ram_rdata`; the unselected `*_rdata` = 0.
- Sub-word extraction and sign extension are the LSU's job, not this block's.

Requester obligations:
- Hold `req` and its payload stable until `gnt` is returned.
- Dropping `req` before `gnt` is legal: the request is silently withdrawn and no response follows.

## Timing
- Reset values (registered state): `owner` = NONE, `wait_cnt` = 0, so `if_rvalid` = `ls_rvalid` = 0 and both `*_rdata` = 0 in the cycle after `rst` is sampled.
- While `rst` = 1:
  - `if_gnt`, `ls_gnt`, `ram_ren` and `ram_wen` are forced to 0, regardless of requests.
  - A read granted in the cycle before `rst` rises produces no `rvalid`; it is dropped.
- Grant latency: 0 cycles (same cycle as `req` when the requester wins).
- Read latency: `rvalid` is asserted exactly 1 cycle after `gnt`.
- Back-to-back reads: an LSU read in cycle N and an IFU read in cycle N+1 give `ls_rvalid` in N+1 and `if_rvalid` in N+2.
- Write in cycle N, read to the same address in N+1: the read returns the new data. This relies on RAM write-first/ordered semantics; the arbiter does no forwarding.
- Worst-case IFU wait under a continuous LSU stream: `MAX_WAIT` denied cycles, then a grant on the next cycle.

## Structure
- `defines.v` gets:
  - Owner encodings `OWN_NONE` = 2'd0, `OWN_IF` = 2'd1, `OWN_LS` = 2'd2.
  - `MAX_WAIT` default `ARB_MAX_WAIT`.
- Bus widths use the existing `` `RegBus ``.
- Single flat module with no sub-module. The only state is the `owner` register and the `wait_cnt` counter.

## Test plan
- Reset hold: `rst` = 1 for 3 cycles with `if_req` = `ls_req` = 1 -> both `gnt` = 0, `ram_ren` = 0, `ram_wen` = 0, both `rvalid` = 0. Then deassert `rst` -> `ls_gnt` = 1 in the same cycle.
- Single IFU read: `if_addr` = 0x100, RAM holds 0xDEADBEEF -> `if_gnt` = 1 in cycle N; `if_rvalid` = 1 with `if_rdata` = 0xDEADBEEF in N+1; `ls_rvalid` = 0.
- Write then read: LSU writes `ls_addr` = 0x40, `ls_wdata` = 0x0000AB00, `ls_wstrb` = 4'b0010 over a RAM word of 0x11223344. Next cycle the LSU reads 0x40 -> `ls_rdata` = 0x1122AB44 in N+2; no `rvalid` for the write.
- Starvation guard (`MAX_WAIT` = 4): `ls_req` and `if_req` held high for 10 cycles -> grant sequence LS, LS, LS, LS, IF, LS, LS, LS, LS, IF; `wait_cnt` returns to 0 after each IF grant.
- Interleaved routing: alternate LS read 0x0 (data 0xA) and IF read 0x4 (data 0xB) for 4 cycles -> `ls_rvalid`/`if_rvalid` alternate one cycle behind the grants, with values 0xA and 0xB respectively and never both high.
- Reset mid-operation: IFU read granted in cycle N, `rst` = 1 in N+1 -> `if_rvalid` = 0 in N+1 and N+2; after `rst` drops, a new IFU read completes normally.
